test_rand_delay_sink: RTL and testbench
=======================================

Name: test_rand_delay_sink

Overview:
- Test-harness sink at the consuming end of a val/rdy message stream.
- Applies pseudo-random backpressure by holding in_rdy low for a random number of cycles before each message.
- Checks each accepted message against a preloaded table of expected values, counts mismatches, and flags completion.
- Pairs with the random-delay source-side elements in unit-test benches.

Parameters:
- p_msg_sz, 8, message width in bits.
- p_max_delay, 0, maximum random delay in cycles inserted before each accept.
- p_num_entries, 16, depth of the expected-message table.
- p_idx_sz, 4, index width; must equal clog2(p_num_entries).
- p_seed, 32'h0000_beef, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ld_en  in  1  write enable for the expected-message table
- ld_addr  in  p_idx_sz  table write address
- ld_data  in  p_msg_sz  table write data
- num_msgs  in  p_idx_sz+1  number of messages to receive; sampled on start
- start  in  1  begin receiving; honoured only in IDLE
- in_val  in  1  upstream message valid
- in_rdy  out  1  sink ready
- in_msg  in  p_msg_sz  upstream message
- done  out  1  high in DONE state
- fail  out  1  one-cycle pulse on a mismatching accept
- num_recv  out  p_idx_sz+1  messages accepted so far
- num_failed  out  16  mismatches so far; saturates at 16'hffff

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE; in_rdy=0, done=0, fail=0, num_recv=0, num_failed=0.
  - lfsr=p_seed; delay counter=0; latched num_msgs=0.
  - Table contents are not reset.
- Table:
  - ld_en writes ld_data to ld_addr at the clock edge, in any state.
  - Reads are combinational at index num_recv. A write and a compare to the same entry in the same cycle compare against the old contents.
- LFSR:
  - 32-bit. next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - "Sample" means: d = lfsr[15:0] mod (p_max_delay+1), taken from the current value; the LFSR advances one step in the same cycle.
  - When p_max_delay=0, d is always 0.
- States: IDLE, DELAY, RECV, DONE (2-bit encoding). in_rdy=1 only in RECV.
- IDLE:
  - On start: latch num_msgs into nm.
  - If nm==0, go to DONE with no sample.
  - Otherwise sample d: d==0 goes to RECV; d>0 goes to DELAY with cnt=d.
- DELAY:
  - in_rdy=0 for exactly d cycles.
  - If cnt==1, go to RECV; otherwise decrement cnt.
- RECV, on in_val & in_rdy (accept):
  - If in_msg != table[num_recv], pulse fail the next cycle and increment num_failed (saturating).
  - Increment num_recv.
  - If the new num_recv==nm, go to DONE; no sample.
  - Otherwise sample d: d==0 stays in RECV (back-to-back accepts possible); d>0 goes to DELAY with cnt=d.
- RECV without in_val: stay, holding in_rdy=1. The delay is counted before rdy, not from when val arrives.
- DONE:
  - done=1, in_rdy=0, regardless of in_val.
  - Leave only via reset; start is ignored.
- start outside IDLE is ignored. in_val in IDLE or DELAY is not accepted, and the message is not dropped: the upstream holds it under val/rdy rules.
- Reset mid-operation returns to IDLE with counters and LFSR re-initialised; table contents are preserved.
- num_msgs greater than p_num_entries is a usage error; behaviour is unspecified.
- Latency: with d=0, a message presented on the cycle RECV is entered is accepted that cycle. num_recv, num_failed and fail update one cycle after the accept edge.

Test Plan:
- p_max_delay=0: load table {0x11,0x22,0x33}, num_msgs=3, start, drive matching messages with in_val held high -> in_rdy=1 for 3 consecutive cycles, num_recv=3, num_failed=0, done=1 on the cycle after the third accept, in_rdy=0 thereafter.
- p_max_delay=0: same table, second message sent as 0x23 -> fail pulses once, num_failed=1, num_recv=3, done=1.
- p_max_delay=4, p_seed=1: 8 matching messages -> every in_rdy-low gap is ≤4 cycles; the gap sequence matches a reference model of the LFSR formula; num_failed=0; done=1.
- num_msgs=0, then start -> done=1 on the next cycle; in_rdy never asserts; num_recv=0.
- Assert reset while in DELAY after 2 of 5 messages -> IDLE with all outputs 0 and the table intact; a restart with num_msgs=5 completes with num_failed=0.
- In DONE, hold in_val=1 and pulse start -> in_rdy stays 0, counters unchanged, done stays 1.

Source files
------------

// File: rtl/test_rand_delay_sink.sv
`default_nettype none
// ============================================================================
// Module : test_rand_delay_sink
// Val/rdy sink with LFSR-driven backpressure; checks messages against a table.
// Rev    : 1.0
// ============================================================================
module test_rand_delay_sink #(
  parameter int          p_msg_sz      = 8,
  parameter int          p_max_delay   = 0,
  parameter int          p_num_entries = 16,
  parameter int          p_idx_sz      = 4,
  parameter logic [31:0] p_seed        = 32'h0000_beef
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_en,
  input  logic [p_idx_sz-1:0] ld_addr,
  input  logic [p_msg_sz-1:0] ld_data,
  input  logic [p_idx_sz:0]   num_msgs,
  input  logic                start,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [p_msg_sz-1:0] in_msg,
  output logic                done,
  output logic                fail,
  output logic [p_idx_sz:0]   num_recv,
  output logic [15:0]         num_failed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RECV  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Divisor for the delay draw; p_max_delay is expected to stay below 65535.
  localparam logic [15:0] DMOD = 16'(p_max_delay + 1);

  state_t              state, state_n;
  logic [31:0]         lfsr;
  logic [15:0]         cnt, cnt_n, d;
  logic [p_idx_sz:0]   nm, nm_n, recv_inc;
  logic [p_msg_sz-1:0] tbl [p_num_entries];
  logic                accept, mismatch, sample;

  assign in_rdy   = (state == RECV);
  assign done     = (state == DONE);
  assign accept   = in_val & in_rdy;
  assign mismatch = accept && (in_msg != tbl[num_recv[p_idx_sz-1:0]]);
  assign recv_inc = num_recv + {{p_idx_sz{1'b0}}, 1'b1};
  assign d        = lfsr[15:0] % DMOD;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    nm_n    = nm;
    sample  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nm_n = num_msgs;
          if (num_msgs == '0) state_n = DONE;
          else                sample  = 1'b1;
        end
      end
      DELAY: begin
        if (cnt == 16'd1) state_n = RECV;
        else              cnt_n   = cnt - 16'd1;
      end
      RECV: begin
        if (accept) begin
          if (recv_inc == nm) state_n = DONE;
          else                sample  = 1'b1;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    // A zero draw keeps (or puts) the sink in RECV so accepts can be back-to-back.
    if (sample) begin
      if (d == 16'd0) begin
        state_n = RECV;
      end else begin
        state_n = DELAY;
        cnt_n   = d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= p_seed;
      cnt        <= '0;
      nm         <= '0;
      num_recv   <= '0;
      num_failed <= '0;
      fail       <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      nm    <= nm_n;
      fail  <= mismatch;
      if (sample) lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      if (accept) num_recv <= recv_inc;
      if (mismatch && (num_failed != 16'hffff)) num_failed <= num_failed + 16'd1;
    end
  end

  // Table survives reset so a test can be restarted without reloading.
  always_ff @(posedge clk) begin
    if (ld_en) tbl[ld_addr] <= ld_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_test_rand_delay_sink.sv
`default_nettype none
// Bench for test_rand_delay_sink: scoreboard of expected gaps/mismatches,
// randomized messages, reference gaps from the LFSR formula.
module tb_test_rand_delay_sink;

  localparam int          MAXD = 4;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic [4:0]  num_msgs = '0;
  logic        start = 1'b0;
  logic        in_val = 1'b0;
  logic [7:0]  in_msg = '0;
  logic        in_rdy, done, fail;
  logic [4:0]  num_recv;
  logic [15:0] num_failed;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  tbl  [16];
  logic [7:0]  msgs [16];
  int          mgap [16];
  int          gap_q[$];
  bit          bad_q[$];
  logic [31:0] mlfsr = SEED;

  bit armed = 0, inrecv = 0, m_idle = 1, chk_pend = 0, done_pend = 0, m_done = 0, exp_fail = 0;
  int run = 0, m_nm = 0, m_recv = 0, m_failed = 0;

  always #5 clk = ~clk;

  test_rand_delay_sink #(
    .p_msg_sz(8), .p_max_delay(MAXD), .p_num_entries(16), .p_idx_sz(4), .p_seed(SEED)
  ) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_msgs(num_msgs), .start(start), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .done(done), .fail(fail), .num_recv(num_recv), .num_failed(num_failed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Monitor: pops expectations whenever the DUT raises rdy or accepts.
  always @(negedge clk) begin
    if (reset) begin
      armed = 0; inrecv = 0; m_idle = 1; chk_pend = 0; done_pend = 0; m_done = 0;
      m_recv = 0; m_failed = 0; run = 0;
    end else begin
      if (chk_pend) begin
        check("fail_pulse", fail, exp_fail);
        check("num_recv", num_recv, m_recv);
        check("num_failed", num_failed, m_failed);
        chk_pend = 0;
      end else begin
        check("fail_idle", fail, 0);
      end
      if (done_pend) begin
        check("done_rise", done, 1);
        m_done = 1; done_pend = 0;
      end else begin
        check("done", done, m_done);
      end
      if (armed && in_rdy) begin
        if (gap_q.size() == 0) begin
          check("gap_unexpected", 1, 0);
        end else begin
          int eg;
          eg = gap_q.pop_front();
          check("gap", run, eg);
          check("gap_bound", (run <= MAXD), 1);
        end
        armed = 0; inrecv = 1;
      end else if (armed) begin
        run++;
      end else begin
        check("rdy", in_rdy, inrecv);
      end
      if (in_val && in_rdy) begin
        if (bad_q.size() == 0) begin
          check("accept_unexpected", 1, 0);
          exp_fail = 0;
        end else begin
          exp_fail = bad_q.pop_front();
        end
        m_recv++;
        if (exp_fail) m_failed++;
        chk_pend = 1; inrecv = 0;
        if (m_recv == m_nm) done_pend = 1;
        else begin armed = 1; run = 0; end
      end
      if (start && m_idle) begin
        m_idle = 0;
        m_nm = int'(num_msgs);
        if (num_msgs == 0) done_pend = 1;
        else begin armed = 1; run = 0; end
      end
    end
  end

  task automatic do_reset();
    reset = 1; in_val = 0; start = 0; ld_en = 0;
    gap_q.delete(); bad_q.delete(); mlfsr = SEED;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdy"}, in_rdy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_recv"}, num_recv, 0);
    check({tag, "_nfail"}, num_failed, 0);
  endtask

  task automatic load(input int a, input logic [7:0] v);
    ld_en = 1; ld_addr = 4'(a); ld_data = v;
    @(posedge clk); #1;
    ld_en = 0; tbl[a] = v;
  endtask

  task automatic start_run(input int nm);
    num_msgs = 5'(nm); start = 1;
    for (int k = 0; k < nm; k++) begin
      mgap[k] = int'(mlfsr[15:0]) % (MAXD + 1);
      gap_q.push_back(mgap[k]);
      mlfsr = lfsr_step(mlfsr);
    end
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input logic [7:0] m, input int k);
    bit acc;
    int n;
    bad_q.push_back(m != tbl[k]);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_val = 1; in_msg = m;
    acc = 0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk); acc = in_rdy;
      @(posedge clk); #1;
      n++;
    end
    in_val = 0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 300) begin @(posedge clk); #1; n++; end
    check("wait_done", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nm, nbad;
    do_reset();
    check_zero("reset");

    // Three matching messages.
    load(0, 8'h11); load(1, 8'h22); load(2, 8'h33);
    start_run(3);
    for (int k = 0; k < 3; k++) send(tbl[k], k);
    wait_done();
    check("s1_recv", num_recv, 3);
    check("s1_nfail", num_failed, 0);

    // Second message corrupted.
    do_reset();
    start_run(3);
    send(8'h11, 0); send(8'h23, 1); send(8'h33, 2);
    wait_done();
    check("s2_recv", num_recv, 3);
    check("s2_nfail", num_failed, 1);

    // Zero messages.
    do_reset();
    start_run(0);
    repeat (3) begin @(posedge clk); #1; end
    check("s3_done", done, 1);
    check("s3_recv", num_recv, 0);

    // Reset in DELAY after two of five, then restart without reloading.
    do_reset();
    for (int a = 0; a < 5; a++) load(a, 8'(8'ha0 + a));
    start_run(5);
    send(tbl[0], 0); send(tbl[1], 1);
    check("s4_mid_rdy", in_rdy, (mgap[2] == 0));
    check("s4_mid_recv", num_recv, 2);
    @(negedge clk); #1;
    do_reset();
    check_zero("midreset");
    start_run(5);
    for (int k = 0; k < 5; k++) send(tbl[k], k);
    wait_done();
    check("s4_recv", num_recv, 5);
    check("s4_nfail", num_failed, 0);

    // DONE ignores in_val and start.
    in_val = 1; in_msg = 8'h5a;
    @(posedge clk); #1;
    num_msgs = 5'd3; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) begin @(posedge clk); #1; end
    check("s5_done", done, 1);
    check("s5_rdy", in_rdy, 0);
    check("s5_recv", num_recv, 5);
    check("s5_nfail", num_failed, 0);
    in_val = 0;

    // Randomized runs.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int a = 0; a < 16; a++) load(a, 8'($urandom));
      nm = $urandom_range(1, 16);
      nbad = 0;
      start_run(nm);
      for (int k = 0; k < nm; k++) begin
        msgs[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : tbl[k];
        if (msgs[k] != tbl[k]) nbad++;
        send(msgs[k], k);
      end
      wait_done();
      check("rnd_recv", num_recv, nm);
      check("rnd_nfail", num_failed, nbad);
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
